// File: rtl/fsx_pkg.sv
// Shared definitions for the frame synthesizer VRAM32 read path.
//   ID_BGW / ID_SPR : requester identifiers carried through the read tag pipe
//   VRAM32_ADDR_W   : VRAM32 word address width
//   VRAM32_DATA_W   : VRAM32 data width
//   rd_tag_t        : {valid, id} tag that follows each granted read
package fsx_pkg;

  localparam int unsigned VRAM32_ADDR_W = 14;
  localparam int unsigned VRAM32_DATA_W = 32;

  typedef enum logic {
    ID_BGW = 1'b0,
    ID_SPR = 1'b1
  } rd_id_e;

  typedef struct packed {
    logic   valid;
    rd_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/vram32_arbiter_if.sv
// Requester-side bus of the VRAM32 read arbiter (BGW and sprite renderers).
//   bgw_req/bgw_addr      : BGW request, address held stable until granted
//   bgw_gnt               : BGW request accepted this cycle
//   bgw_rvalid/bgw_rdata  : one-cycle return pulse, data held until next pulse
//   spr_*                 : same set for the sprite renderer
// Modports: master = requesters, slave = arbiter.
interface vram32_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);

  logic              bgw_req;
  logic [ADDR_W-1:0] bgw_addr;
  logic              bgw_gnt;
  logic              bgw_rvalid;
  logic [DATA_W-1:0] bgw_rdata;

  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_gnt;
  logic              spr_rvalid;
  logic [DATA_W-1:0] spr_rdata;

  modport master (
    output bgw_req, bgw_addr, spr_req, spr_addr,
    input  bgw_gnt, bgw_rvalid, bgw_rdata,
    input  spr_gnt, spr_rvalid, spr_rdata
  );

  modport slave (
    input  bgw_req, bgw_addr, spr_req, spr_addr,
    output bgw_gnt, bgw_rvalid, bgw_rdata,
    output spr_gnt, spr_rvalid, spr_rdata
  );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, id} read tags, aligned with the
// VRAM32 read latency so the exit stage coincides with vram32_q.
//   vga_clk, nreset : clock, asynchronous active-low clear of every stage
//   tag_in          : tag of the read granted this cycle
//   tag_out         : exit-stage tag (valid + id)
module vram_rd_tag_pipe
  import fsx_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    vga_clk,
  input  logic    nreset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [RD_LAT];
  rd_tag_t stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/vram32_arbiter.sv
// Shares one synchronous VRAM32 read port between the BGW renderer and the
// sprite renderer. At most one read is granted per vga_clk; the returned word
// is routed back to whichever side issued it.
//   vga_clk, nreset : pixel clock, asynchronous active-low reset
//   display_active  : 1 = BGW preferred (active video), 0 = SPR preferred
//   bus             : requester handshake (slave side)
//   vram32_addr     : VRAM32 read address (holds last granted address when idle)
//   vram32_q        : VRAM32 read data, valid RD_LAT cycles after its address
module vram32_arbiter
  import fsx_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM32_ADDR_W,
  parameter int unsigned DATA_W   = VRAM32_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              vga_clk,
  input  logic              nreset,
  input  logic              display_active,
  vram32_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0] vram32_addr,
  input  logic [DATA_W-1:0] vram32_q
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic              bgw_gnt_c, spr_gnt_c;
  logic [3:0]        bgw_wait_q, bgw_wait_d;
  logic [3:0]        spr_wait_q, spr_wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bgw_rvalid_q, bgw_rvalid_d;
  logic              spr_rvalid_q, spr_rvalid_d;
  logic [DATA_W-1:0] bgw_rdata_q, bgw_rdata_d;
  logic [DATA_W-1:0] spr_rdata_q, spr_rdata_d;
  rd_tag_t           tag_in, tag_out;

  // Grant: a lone requester always wins; on contention the non-preferred side
  // wins only when it has waited MAX_WAIT cycles and the preferred side has not.
  always_comb begin
    bgw_gnt_c = 1'b0;
    spr_gnt_c = 1'b0;
    if (nreset) begin
      if (bus.bgw_req && bus.spr_req) begin
        if (display_active) begin
          spr_gnt_c = (spr_wait_q == WAIT_MAX) && (bgw_wait_q != WAIT_MAX);
          bgw_gnt_c = !spr_gnt_c;
        end else begin
          bgw_gnt_c = (bgw_wait_q == WAIT_MAX) && (spr_wait_q != WAIT_MAX);
          spr_gnt_c = !bgw_gnt_c;
        end
      end else begin
        bgw_gnt_c = bus.bgw_req;
        spr_gnt_c = bus.spr_req;
      end
    end
  end

  // Wait counters only run while a side is requesting and losing.
  always_comb begin
    bgw_wait_d = '0;
    spr_wait_d = '0;
    if (bus.bgw_req && !bgw_gnt_c) begin
      bgw_wait_d = (bgw_wait_q == WAIT_MAX) ? WAIT_MAX : bgw_wait_q + 4'd1;
    end
    if (bus.spr_req && !spr_gnt_c) begin
      spr_wait_d = (spr_wait_q == WAIT_MAX) ? WAIT_MAX : spr_wait_q + 4'd1;
    end
  end

  // Address follows the grant combinationally and parks on the last grant.
  always_comb begin
    addr_d = addr_q;
    if (bgw_gnt_c) begin
      addr_d = bus.bgw_addr;
    end else if (spr_gnt_c) begin
      addr_d = bus.spr_addr;
    end
  end

  assign vram32_addr = addr_d;

  always_comb begin
    tag_in.valid = bgw_gnt_c || spr_gnt_c;
    tag_in.id    = spr_gnt_c ? ID_SPR : ID_BGW;
  end

  vram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .vga_clk (vga_clk),
    .nreset  (nreset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Exit tag lines up with vram32_q; capture into the owner's data register.
  always_comb begin
    bgw_rvalid_d = tag_out.valid && (tag_out.id == ID_BGW);
    spr_rvalid_d = tag_out.valid && (tag_out.id == ID_SPR);
    bgw_rdata_d  = bgw_rvalid_d ? vram32_q : bgw_rdata_q;
    spr_rdata_d  = spr_rvalid_d ? vram32_q : spr_rdata_q;
  end

  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      bgw_wait_q   <= '0;
      spr_wait_q   <= '0;
      addr_q       <= '0;
      bgw_rvalid_q <= 1'b0;
      spr_rvalid_q <= 1'b0;
      bgw_rdata_q  <= '0;
      spr_rdata_q  <= '0;
    end else begin
      bgw_wait_q   <= bgw_wait_d;
      spr_wait_q   <= spr_wait_d;
      addr_q       <= addr_d;
      bgw_rvalid_q <= bgw_rvalid_d;
      spr_rvalid_q <= spr_rvalid_d;
      bgw_rdata_q  <= bgw_rdata_d;
      spr_rdata_q  <= spr_rdata_d;
    end
  end

  assign bus.bgw_gnt    = bgw_gnt_c;
  assign bus.spr_gnt    = spr_gnt_c;
  assign bus.bgw_rvalid = bgw_rvalid_q;
  assign bus.spr_rvalid = spr_rvalid_q;
  assign bus.bgw_rdata  = bgw_rdata_q;
  assign bus.spr_rdata  = spr_rdata_q;

endmodule
